// File: rtl/invert_xform_pipe.sv
// Mode-selectable bit transform feeding an elastic STAGES-deep valid/ready pipeline,
// with a wrapping count of completed output handshakes.
module invert_xform_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [15:0]      xfer_count
);

  localparam int unsigned Q = WIDTH / 4;
  localparam int unsigned H = WIDTH / 2;

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("invert_xform_pipe: WIDTH must be a multiple of 4 and at least 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("invert_xform_pipe: STAGES must be in 1..4");
  end

  logic [Q-1:0]     q0, q1, q2, q3;
  logic [H-1:0]     h0, h1, c;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] xf;

  assign q0 = in_data[Q-1:0];
  assign q1 = in_data[2*Q-1:Q];
  assign q2 = in_data[3*Q-1:2*Q];
  assign q3 = in_data[4*Q-1:3*Q];
  assign h0 = in_data[H-1:0];
  assign h1 = in_data[WIDTH-1:H];
  assign c  = (h1 == h0) ? ~h0 : h1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev[i] = in_data[WIDTH-1-i];
  end

  always_comb begin
    xf = in_data;
    unique case (in_mode)
      2'd0: xf = {c, q3 ^ q2, ~q0 | ~q1};
      2'd1: xf = ~in_data;
      2'd2: xf = rev;
      2'd3: xf = in_data;
    endcase
  end

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] rdy;

  // Flattened ready chain: a stage may load if it or any later stage has room,
  // or the consumer is taking the last beat.
  for (genvar i = 0; i < STAGES; i++) begin : g_rdy
    assign rdy[i] = out_ready | ~(&valid_q[STAGES-1:i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (rdy[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= xf;
        end
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (rdy[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + 16'd1;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_invert_xform_pipe.sv
// Scoreboard bench for invert_xform_pipe: a 32-bit/2-stage instance under directed and
// random traffic, plus 16-bit/1-stage (counter wrap) and 64-bit/4-stage instances.
module tb_invert_xform_pipe;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_aux = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference transform computed from field arithmetic on a 64-bit container.
  function automatic logic [63:0] ref_xf(input logic [63:0] din, input int w,
                                         input logic [1:0] m);
    logic [63:0] d, wm, hm, qm, h1, h0, q3, q2, q1, q0, c, r;
    int q, h;
    q  = w / 4;
    h  = w / 2;
    wm = (64'd1 << w) - 64'd1;
    hm = (64'd1 << h) - 64'd1;
    qm = (64'd1 << q) - 64'd1;
    d  = din & wm;
    h0 = d & hm;
    h1 = (d >> h) & hm;
    q0 = d & qm;
    q1 = (d >> q) & qm;
    q2 = (d >> (2 * q)) & qm;
    q3 = (d >> (3 * q)) & qm;
    r  = 64'd0;
    case (m)
      2'd0: begin
        c = (h1 == h0) ? (~h0 & hm) : h1;
        r = (c << h) | ((q3 ^ q2) << q) | ((~q0 | ~q1) & qm);
      end
      2'd1: r = ~d & wm;
      2'd2: for (int i = 0; i < w; i++) r[i] = d[w-1-i];
      default: r = d;
    endcase
    return r;
  endfunction

  // ---------------- main instance: WIDTH 32, STAGES 2 ----------------
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [31:0] in_data = '0, out_data;
  logic [1:0]  in_mode = '0;
  logic [15:0] xfer_count;

  invert_xform_pipe #(.WIDTH(32), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .xfer_count(xfer_count)
  );

  logic [31:0] exp_q[$];
  int          out_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("main_data", 64'(out_data), 64'(exp_q.pop_front()));
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  int acc_cyc = 0;

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [31:0] e);
    bit got;
    got = 1'b0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        acc_cyc = cyc;
        got = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) fail_now("send_timeout");
  endtask

  task automatic send_rand();
    logic [31:0] d;
    logic [1:0]  m;
    logic [63:0] r;
    d = $urandom;
    m = 2'($urandom_range(0, 3));
    r = ref_xf(64'(d), 32, m);
    send(d, m, r[31:0]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_cnt = 0;
  endtask

  // ---------------- 16-bit, 1-stage instance: stream and wrap ----------------
  logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_busy;
  logic [15:0] s_in_data = '0, s_out_data, s_xfer;
  logic [1:0]  s_in_mode = '0;
  logic [15:0] s_q[$];
  int          s_cnt = 0;
  bit          s_done = 1'b0;

  invert_xform_pipe #(.WIDTH(16), .STAGES(1)) dut16 (
    .clk(clk), .rst(rst_aux), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy), .xfer_count(s_xfer)
  );

  always @(negedge clk) begin
    if (!rst_aux && s_out_valid && s_out_ready) begin
      if (s_q.size() == 0) fail_now("s_unexpected_beat");
      else check("s_data", 64'(s_out_data), 64'(s_q.pop_front()));
      check("s_count", 64'(s_xfer), 64'(s_cnt[15:0]));
      s_cnt++;
    end
  end

  initial begin
    logic [63:0] r;
    wait (rst_aux == 1'b0);
    @(posedge clk);
    #1;
    s_out_ready = 1'b1;
    while (s_cnt < 65536) begin
      s_in_valid = 1'b1;
      s_in_data  = 16'($urandom);
      s_in_mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      if (s_in_ready) begin
        r = ref_xf(64'(s_in_data), 16, s_in_mode);
        s_q.push_back(r[15:0]);
      end
      @(posedge clk);
      #1;
    end
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    check("s_wrap_zero", 64'(s_xfer), 64'd0);
    check("s_busy_inflight", 64'(s_busy), 64'd1);
    s_done = 1'b1;
  end

  // ---------------- 64-bit, 4-stage instance: random traffic ----------------
  logic        l_in_valid = 1'b0, l_in_ready, l_out_valid, l_out_ready = 1'b0, l_busy;
  logic [63:0] l_in_data = '0, l_out_data;
  logic [1:0]  l_in_mode = '0;
  logic [15:0] l_xfer;
  logic [63:0] l_q[$];
  int          l_cnt = 0;
  bit          l_done = 1'b0;

  invert_xform_pipe #(.WIDTH(64), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst_aux), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .in_mode(l_in_mode), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_data(l_out_data), .busy(l_busy), .xfer_count(l_xfer)
  );

  always @(negedge clk) begin
    if (!rst_aux && l_out_valid && l_out_ready) begin
      if (l_q.size() == 0) fail_now("l_unexpected_beat");
      else check("l_data", l_out_data, l_q.pop_front());
      l_cnt++;
    end
  end

  initial begin
    int sent, guard;
    bit hold;
    sent = 0;
    guard = 0;
    hold = 1'b0;
    wait (rst_aux == 1'b0);
    @(posedge clk);
    #1;
    while ((sent < 300 || l_q.size() != 0) && guard < 20000) begin
      if (!hold) begin
        l_in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
        l_in_data  = {$urandom, $urandom};
        l_in_mode  = 2'($urandom_range(0, 3));
      end
      l_out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (l_in_valid && l_in_ready) begin
        l_q.push_back(ref_xf(l_in_data, 64, l_in_mode));
        sent++;
        hold = 1'b0;
      end else begin
        hold = l_in_valid;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    l_in_valid = 1'b0;
    check("l_drained", 64'(l_q.size()), 64'd0);
    check("l_count", 64'(l_xfer), 64'(l_cnt[15:0]));
    check("l_idle", 64'(l_busy), 64'd0);
    l_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, c0, cnt0, first, n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_aux = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_xfer", 64'(xfer_count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    // T1: legacy mode vectors and latency
    out_ready = 1'b1;
    send(32'h12341234, 2'd0, 32'hEDCB26EF);
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      if (out_valid) lat = cyc - acc_cyc;
    end
    @(posedge clk);
    #1;
    check("t1_latency", 64'(lat), 64'(S));
    send(32'hAABBCCDD, 2'd0, 32'hAABB1133);
    drain("t1");

    // T2: other modes, then mixed modes back-to-back
    send(32'h0000FFFF, 2'd1, 32'hFFFF0000);
    send(32'h00000001, 2'd2, 32'h80000000);
    send(32'hDEADBEEF, 2'd3, 32'hDEADBEEF);
    repeat (24) send_rand();
    drain("t2");

    // T3: fill under backpressure, third beat refused until release
    cnt0 = out_cnt;
    out_ready = 1'b0;
    send_rand();
    send_rand();
    check("t3_in_ready_full", 64'(in_ready), 64'd0);
    check("t3_busy", 64'(busy), 64'd1);
    in_data  = $urandom;
    in_mode  = 2'd1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t3_still_blocked", 64'(in_ready), 64'd0);
    check("t3_no_output", 64'(out_cnt - cnt0), 64'd0);
    out_ready = 1'b1;
    c0 = cyc;
    send_rand();
    check("t3_simul_accept", 64'(acc_cyc - c0), 64'd0);
    drain("t3");
    check("t3_beats_out", 64'(out_cnt - cnt0), 64'd3);

    // T4: full-rate streaming, then random backpressure
    do_reset();
    out_ready = 1'b1;
    send_rand();
    first = acc_cyc;
    repeat (99) send_rand();
    check("t4_rate", 64'(acc_cyc - first), 64'd99);
    drain("t4a");
    check("t4_xfer_100", 64'(xfer_count), 64'd100);
    check("t4_out_100", 64'(out_cnt), 64'd100);
    rand_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    drain("t4b");
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    check("t4_xfer_match", 64'(xfer_count), 64'(out_cnt[15:0]));

    // T5: reset with a full pipeline discards everything
    out_ready = 1'b0;
    send_rand();
    send_rand();
    check("t5_busy_full", 64'(busy), 64'd1);
    do_reset();
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_xfer", 64'(xfer_count), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    check("t5_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_stale", 64'(out_cnt), 64'd0);
    repeat (5) send_rand();
    drain("t5");
    check("t5_resume", 64'(out_cnt), 64'd5);

    n = 0;
    while (!(s_done && l_done) && n < 80000) begin
      @(posedge clk);
      n++;
    end
    if (!(s_done && l_done)) fail_now("aux_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
